barrel_normalizer: RTL and testbench
====================================

BARREL_NORMALIZER -- requirements
Module: barrel_normalizer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width; only 32 is supported.
REQ-002 SHALL have port i_clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_valid  input  1  input word offered.
REQ-005 SHALL have port o_ready  output  1  block accepts input this cycle.
REQ-006 SHALL have port i_signed  input  1  1 = two's-complement normalize, 0 = unsigned.
REQ-007 SHALL have port i_data  input  32  word to normalize.
REQ-008 SHALL have port o_valid  output  1  result available.
REQ-009 SHALL have port i_ready  input  1  consumer takes result.
REQ-010 SHALL have port o_data  output  32  normalized word.
REQ-011 SHALL have port o_shift_amt  output  5  left-shift applied.
REQ-012 SHALL have port o_zero  output  1  input had no significant bits (unsigned 0, signed 0 or -1).

Function
REQ-013 SHALL accept a word when i_valid && o_ready; i_data and i_signed are captured on that edge.
REQ-014 SHALL drive o_ready = 1 only in state IDLE.
REQ-015 SHALL use FSM states IDLE, STEP16, STEP4, STEP1, DONE: IDLE->STEP16 on accept; STEP16->STEP4->STEP1->DONE unconditionally; DONE->IDLE when i_ready.
REQ-016 SHALL assert o_valid only in DONE: first o_valid exactly 4 cycles after the accept edge.
REQ-017 SHALL hold o_data, o_shift_amt and o_zero stable while o_valid && !i_ready.
REQ-018 SHALL NOT accept a new word in the DONE cycle where i_ready is high (no overlap); next accept earliest in the following IDLE cycle.
REQ-019 Unsigned: o_shift_amt = count of leading zeros of i_data, saturated at 31.
REQ-020 Signed: o_shift_amt = (count of leading bits equal to i_data[31]) - 1, saturated at 31.
REQ-021 SHALL produce o_data = i_data << o_shift_amt, zero-filled from the LSB, in both modes.
REQ-022 STEP16: if the top 16 bits of the working word are redundant, shift the working word left by 16 and add 16 to the count.
REQ-023 STEP4: shift left by the largest of 12, 8, 4 or 0 whose bits are all redundant; add the same amount to the count.
REQ-024 STEP1: shift left by the largest of 3, 2, 1 or 0 the same way.
REQ-025 Redundancy test in signed mode SHALL compare against the captured bit 31 and SHALL stop one bit early, so that o_data[30] != o_data[31] when o_zero = 0.
REQ-026 Count SHALL be 5 bits; 16+12+3 = 31 max, no overflow possible.
REQ-027 SHALL set o_zero = 1 for unsigned input 0x0000_0000 (o_shift_amt 31, o_data 0) and for signed input 0x0000_0000 or 0xFFFF_FFFF (o_shift_amt 31).
REQ-028 Input 0x8000_0000 unsigned, or any signed input with bit30 != bit31, SHALL yield o_shift_amt 0 and o_data = i_data.

Reset
REQ-029 While i_rst_n = 0: state IDLE, o_valid 0, o_ready 1 after release, o_data 0, o_shift_amt 0, o_zero 0, working registers 0.
REQ-030 Reset asserted mid-operation (any state) SHALL abort the word immediately; no o_valid for it after release.

Structure
REQ-031 SHALL place the FSM state enum and constants DATA_W = 32 and SHAMT_W = 5 in a shared package barrel_pkg.
REQ-032 SHALL use one sub-module, norm_step, combinational, parameterized by step sizes, returning a shift amount and the shifted word; it is instantiated once per STEP state or shared.

Verification
REQ-033 Unsigned 0x0000_0001 -> after 4 cycles o_valid, o_shift_amt 31, o_data 0x8000_0000, o_zero 0.
REQ-034 Unsigned 0x0001_0000 -> o_shift_amt 15, o_data 0x8000_0000; unsigned 0 -> o_shift_amt 31, o_data 0, o_zero 1.
REQ-035 Signed 0xFFFF_FFF0 -> o_shift_amt 27, o_data 0x8000_0000; signed 0x0000_00FF -> o_shift_amt 23, o_data 0x7F80_0000.
REQ-036 i_ready held 0 for 5 cycles in DONE -> outputs stable, o_ready 0 throughout; i_ready 1 -> IDLE the next cycle with o_ready 1.
REQ-037 i_rst_n pulsed low in STEP4 -> o_valid never asserts for that word; a fresh 0x0000_0100 unsigned then returns o_shift_amt 23.
REQ-038 Random 10k words, both modes, random i_ready -> match the reference model for REQ-019..021 and REQ-027.

Source files
------------

// File: rtl/barrel_pkg.sv
// Shared types and widths for the leading-bit normalizer and its shift-step helper.
package barrel_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [2:0] {
    IDLE,
    STEP16,
    STEP4,
    STEP1,
    DONE
  } state_e;

endpackage

// File: rtl/norm_step.sv
// One combinational normalize step: shifts left by the largest of STEP*N .. STEP*1 (or 0) whose
// leading bits are redundant. Unsigned redundancy means zero; signed means equal to the captured sign.
module norm_step
  import barrel_pkg::*;
#(
  parameter int STEP = 4,
  parameter int N    = 3
) (
  input  logic [DATA_W-1:0]  i_word,
  input  logic               i_signed,
  input  logic               i_sign,
  output logic [SHAMT_W-1:0] o_amt,
  output logic [DATA_W-1:0]  o_word
);

  logic [DATA_W-1:0] diff;
  logic [N-1:0]      pass;

  // In signed mode a bit is redundant when it matches the sign; XOR turns that into a zero test.
  assign diff = i_word ^ {DATA_W{i_signed & i_sign}};

  for (genvar k = 0; k < N; k++) begin : g_cand
    localparam int AMT = (k + 1) * STEP;
    // Signed needs one extra matching bit so the sign still sits in bit 31 after the shift.
    assign pass[k] = i_signed ? (diff[DATA_W-1 -: AMT+1] == '0)
                              : (diff[DATA_W-1 -: AMT]   == '0);
  end

  // Candidates pass monotonically, so the last one that passes is the largest.
  always_comb begin
    o_amt = '0;
    for (int k = 0; k < N; k++) begin
      if (pass[k]) o_amt = SHAMT_W'((k + 1) * STEP);
    end
  end

  assign o_word = i_word << o_amt;

endmodule

// File: rtl/barrel_normalizer.sv
// Leading-bit normalizer (unsigned or two's-complement) in 16/4/1 steps; result in DONE, the 4th cycle after the accept cycle.
// One word in flight: o_ready only in IDLE, result held in DONE until i_ready.
module barrel_normalizer #(
  parameter int DATA_W = 32
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic                           i_signed,
  input  logic [DATA_W-1:0]              i_data,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [DATA_W-1:0]              o_data,
  output logic [barrel_pkg::SHAMT_W-1:0] o_shift_amt,
  output logic                           o_zero
);

  import barrel_pkg::*;

  state_e               state_q, state_d;
  logic [DATA_W-1:0]    work_q, work_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;
  logic                 sign_q, sign_d;
  logic                 mode_q, mode_d;
  logic                 in_zero_q, in_zero_d;
  logic [DATA_W-1:0]    out_data_q, out_data_d;
  logic [SHAMT_W-1:0]   out_amt_q, out_amt_d;
  logic                 out_zero_q, out_zero_d;

  logic [SHAMT_W-1:0]   amt16, amt4, amt1;
  logic [DATA_W-1:0]    word16, word4, word1;

  norm_step #(.STEP(16), .N(1)) u_step16 (
    .i_word   (work_q),
    .i_signed (mode_q),
    .i_sign   (sign_q),
    .o_amt    (amt16),
    .o_word   (word16)
  );

  norm_step #(.STEP(4), .N(3)) u_step4 (
    .i_word   (work_q),
    .i_signed (mode_q),
    .i_sign   (sign_q),
    .o_amt    (amt4),
    .o_word   (word4)
  );

  norm_step #(.STEP(1), .N(3)) u_step1 (
    .i_word   (work_q),
    .i_signed (mode_q),
    .i_sign   (sign_q),
    .o_amt    (amt1),
    .o_word   (word1)
  );

  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    cnt_d      = cnt_q;
    sign_d     = sign_q;
    mode_d     = mode_q;
    in_zero_d  = in_zero_q;
    out_data_d = out_data_q;
    out_amt_d  = out_amt_q;
    out_zero_d = out_zero_q;
    o_ready    = (state_q == IDLE);
    o_valid    = (state_q == DONE);

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          state_d   = STEP16;
          work_d    = i_data;
          cnt_d     = '0;
          sign_d    = i_data[DATA_W-1];
          mode_d    = i_signed;
          in_zero_d = (i_data == '0) || (i_signed && (i_data == '1));
        end
      end
      STEP16: begin
        work_d  = word16;
        cnt_d   = cnt_q + amt16;
        state_d = STEP4;
      end
      STEP4: begin
        work_d  = word4;
        cnt_d   = cnt_q + amt4;
        state_d = STEP1;
      end
      STEP1: begin
        // Results land in dedicated registers so they stay frozen through a DONE stall.
        work_d     = word1;
        cnt_d      = cnt_q + amt1;
        out_data_d = word1;
        out_amt_d  = cnt_q + amt1;
        out_zero_d = in_zero_q;
        state_d    = DONE;
      end
      DONE: begin
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      work_q     <= '0;
      cnt_q      <= '0;
      sign_q     <= 1'b0;
      mode_q     <= 1'b0;
      in_zero_q  <= 1'b0;
      out_data_q <= '0;
      out_amt_q  <= '0;
      out_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      cnt_q      <= cnt_d;
      sign_q     <= sign_d;
      mode_q     <= mode_d;
      in_zero_q  <= in_zero_d;
      out_data_q <= out_data_d;
      out_amt_q  <= out_amt_d;
      out_zero_q <= out_zero_d;
    end
  end

  assign o_data      = out_data_q;
  assign o_shift_amt = out_amt_q;
  assign o_zero      = out_zero_q;

endmodule

// File: tb/tb_barrel_normalizer.sv
// Scoreboard bench for barrel_normalizer: directed vectors, stall, mid-operation reset, back-to-back and random traffic.
module tb_barrel_normalizer;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic        i_signed;
  logic [31:0] i_data;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_data;
  logic [4:0]  o_shift_amt;
  logic        o_zero;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  s;
    logic        z;
  } exp_t;

  typedef struct {
    logic [31:0] in;
    logic        sg;
    logic [31:0] d;
    logic [4:0]  s;
    logic        z;
  } vec_t;

  exp_t sb[$];

  always #5 i_clk = ~i_clk;

  barrel_normalizer #(.DATA_W(32)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_signed    (i_signed),
    .i_data      (i_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_data      (o_data),
    .o_shift_amt (o_shift_amt),
    .o_zero      (o_zero)
  );

  // Reference: count leading redundant bits directly, bit by bit.
  function automatic exp_t model(input logic [31:0] d, input logic sgn);
    exp_t e;
    int   n;
    logic run;
    n   = 0;
    run = 1'b1;
    for (int i = 31; i >= 0; i--) begin
      if (run && (d[i] == (sgn ? d[31] : 1'b0))) n++;
      else run = 1'b0;
    end
    if (sgn) n = n - 1;
    if (n > 31) n = 31;
    e.s = 5'(n);
    e.d = d << e.s;
    e.z = sgn ? ((d == 32'h0) || (d == 32'hFFFF_FFFF)) : (d == 32'h0);
    return e;
  endfunction

  task automatic test_reset;
    i_rst_n  = 1'b0;
    i_valid  = 1'b0;
    i_ready  = 1'b0;
    i_signed = 1'b0;
    i_data   = 32'h0;
    repeat (3) @(negedge i_clk);
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    tests++; if (o_data !== 32'h0) begin fails++; $display("FAIL reset_data: got %h want 00000000", o_data); end
    tests++; if (o_shift_amt !== 5'd0) begin fails++; $display("FAIL reset_shamt: got %0d want 0", o_shift_amt); end
    tests++; if (o_zero !== 1'b0) begin fails++; $display("FAIL reset_zero: got %b want 0", o_zero); end
    i_rst_n = 1'b1;
    @(negedge i_clk);
    tests++; if (o_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", o_ready); end
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid_after: got %b want 0", o_valid); end
  endtask

  task automatic test_directed;
    vec_t v[11];
    exp_t e;
    int   n;
    v[0]  = '{32'h0000_0001, 1'b0, 32'h8000_0000, 5'd31, 1'b0};
    v[1]  = '{32'h0001_0000, 1'b0, 32'h8000_0000, 5'd15, 1'b0};
    v[2]  = '{32'h0000_0000, 1'b0, 32'h0000_0000, 5'd31, 1'b1};
    v[3]  = '{32'hFFFF_FFF0, 1'b1, 32'h8000_0000, 5'd27, 1'b0};
    v[4]  = '{32'h0000_00FF, 1'b1, 32'h7F80_0000, 5'd23, 1'b0};
    v[5]  = '{32'h8000_0000, 1'b0, 32'h8000_0000, 5'd0,  1'b0};
    v[6]  = '{32'h4000_0000, 1'b1, 32'h4000_0000, 5'd0,  1'b0};
    v[7]  = '{32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 5'd31, 1'b1};
    v[8]  = '{32'h0000_0000, 1'b1, 32'h0000_0000, 5'd31, 1'b1};
    v[9]  = '{32'hC000_0000, 1'b1, 32'h8000_0000, 5'd1,  1'b0};
    v[10] = '{32'h0000_0003, 1'b0, 32'hC000_0000, 5'd30, 1'b0};
    for (int i = 0; i < 11; i++) begin
      tests++; if (o_ready !== 1'b1) begin fails++; $display("FAIL dir%0d_ready: got %b want 1", i, o_ready); end
      i_valid  = 1'b1;
      i_data   = v[i].in;
      i_signed = v[i].sg;
      i_ready  = 1'b1;
      e.d = v[i].d; e.s = v[i].s; e.z = v[i].z;
      sb.push_back(e);
      @(negedge i_clk);
      i_valid = 1'b0;
      n = 1;
      while (o_valid !== 1'b1 && n < 10) begin
        @(negedge i_clk);
        n++;
      end
      tests++; if (n != 4) begin fails++; $display("FAIL dir%0d_latency: got %0d want 4", i, n); end
      if (o_valid === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        tests++; if (o_data !== e.d) begin fails++; $display("FAIL dir%0d_data: got %h want %h", i, o_data, e.d); end
        tests++; if (o_shift_amt !== e.s) begin fails++; $display("FAIL dir%0d_shamt: got %0d want %0d", i, o_shift_amt, e.s); end
        tests++; if (o_zero !== e.z) begin fails++; $display("FAIL dir%0d_zero: got %b want %b", i, o_zero, e.z); end
      end else begin
        tests++; fails++;
        $display("FAIL dir%0d_timeout: got o_valid %b want 1", i, o_valid);
        sb.delete();
      end
      @(negedge i_clk);
    end
  endtask

  task automatic test_stall;
    exp_t e;
    int   n;
    i_valid  = 1'b1;
    i_data   = 32'h0000_0F00;
    i_signed = 1'b0;
    i_ready  = 1'b0;
    sb.push_back('{32'hF000_0000, 5'd20, 1'b0});
    @(negedge i_clk);
    i_valid = 1'b0;
    n = 1;
    while (o_valid !== 1'b1 && n < 10) begin
      @(negedge i_clk);
      n++;
    end
    if (o_valid !== 1'b1) begin
      tests++; fails++;
      $display("FAIL stall_timeout: got o_valid %b want 1", o_valid);
      sb.delete();
    end else begin
      e = sb.pop_front();
      for (int c = 0; c < 5; c++) begin
        tests++; if (o_valid !== 1'b1) begin fails++; $display("FAIL stall%0d_valid: got %b want 1", c, o_valid); end
        tests++; if (o_ready !== 1'b0) begin fails++; $display("FAIL stall%0d_ready: got %b want 0", c, o_ready); end
        tests++; if ({o_data, o_shift_amt, o_zero} !== e) begin
          fails++; $display("FAIL stall%0d_out: got %h/%0d/%b want %h/%0d/%b", c, o_data, o_shift_amt, o_zero, e.d, e.s, e.z);
        end
        @(negedge i_clk);
      end
    end
    i_ready = 1'b1;
    @(negedge i_clk);
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL stall_release_valid: got %b want 0", o_valid); end
    tests++; if (o_ready !== 1'b1) begin fails++; $display("FAIL stall_release_ready: got %b want 1", o_ready); end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    int   n;
    i_valid  = 1'b1;
    i_data   = 32'h1234_5678;
    i_signed = 1'b0;
    i_ready  = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid: got %b want 0", o_valid); end
    tests++; if (o_ready !== 1'b1) begin fails++; $display("FAIL rstmid_ready: got %b want 1", o_ready); end
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge i_clk);
      tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL rstmid_ghost%0d: got %b want 0", c, o_valid); end
    end
    i_valid  = 1'b1;
    i_data   = 32'h0000_0100;
    i_signed = 1'b0;
    sb.push_back('{32'h8000_0000, 5'd23, 1'b0});
    @(negedge i_clk);
    i_valid = 1'b0;
    n = 1;
    while (o_valid !== 1'b1 && n < 10) begin
      @(negedge i_clk);
      n++;
    end
    tests++; if (n != 4) begin fails++; $display("FAIL rstmid_latency: got %0d want 4", n); end
    if (o_valid === 1'b1) begin
      e = sb.pop_front();
      tests++; if ({o_data, o_shift_amt, o_zero} !== e) begin
        fails++; $display("FAIL rstmid_fresh: got %h/%0d/%b want %h/%0d/%b", o_data, o_shift_amt, o_zero, e.d, e.s, e.z);
      end
    end else begin
      tests++; fails++;
      $display("FAIL rstmid_timeout: got o_valid %b want 1", o_valid);
      sb.delete();
    end
    @(negedge i_clk);
  endtask

  task automatic test_back_to_back;
    logic [31:0] words[3];
    logic        sgns[3];
    exp_t        e;
    int sent = 0, got = 0, last = -1, cyc = 0;
    words[0] = 32'h0000_00F0; sgns[0] = 1'b0;
    words[1] = 32'hFFFF_8000; sgns[1] = 1'b1;
    words[2] = 32'h0007_0000; sgns[2] = 1'b1;
    i_ready = 1'b1;
    while (got < 3 && cyc < 60) begin
      tests++; if (o_valid === 1'b1 && o_ready === 1'b1) begin
        fails++; $display("FAIL b2b_overlap: got valid&ready 1 want 0 at cycle %0d", cyc);
      end
      if (o_valid === 1'b1) begin
        if (sb.size() == 0) begin
          tests++; fails++; $display("FAIL b2b_extra: got output %h want none", o_data);
        end else begin
          e = sb.pop_front();
          tests++; if ({o_data, o_shift_amt, o_zero} !== e) begin
            fails++; $display("FAIL b2b%0d_out: got %h/%0d/%b want %h/%0d/%b", got, o_data, o_shift_amt, o_zero, e.d, e.s, e.z);
          end
        end
        if (last >= 0) begin
          tests++; if (cyc - last != 5) begin fails++; $display("FAIL b2b_spacing: got %0d want 5", cyc - last); end
        end
        last = cyc;
        got++;
      end
      if (o_ready === 1'b1 && sent < 3) begin
        i_valid  = 1'b1;
        i_data   = words[sent];
        i_signed = sgns[sent];
        sb.push_back(model(words[sent], sgns[sent]));
        sent++;
      end else if (o_ready === 1'b1) begin
        i_valid = 1'b0;
      end
      @(negedge i_clk);
      cyc++;
    end
    i_valid = 1'b0;
    if (got < 3) begin
      tests++; fails++; $display("FAIL b2b_timeout: got %0d results want 3", got);
      sb.delete();
    end
  endtask

  task automatic test_random;
    localparam int NW = 10000;
    exp_t        e;
    logic [31:0] r, d;
    logic        sg;
    int sent = 0, got = 0, cyc = 0;
    while (got < NW && cyc < 80000) begin
      @(negedge i_clk);
      cyc++;
      i_ready = ($urandom_range(0, 4) != 0);
      if (o_valid === 1'b1 && i_ready) begin
        if (sb.size() == 0) begin
          tests++; fails++; $display("FAIL rnd_extra: got output %h want none", o_data);
        end else begin
          e = sb.pop_front();
          tests++; if ({o_data, o_shift_amt, o_zero} !== e) begin
            fails++; $display("FAIL rnd%0d_out: got %h/%0d/%b want %h/%0d/%b", got, o_data, o_shift_amt, o_zero, e.d, e.s, e.z);
          end
        end
        got++;
      end
      if (o_ready === 1'b1 && sent < NW) begin
        r = $urandom;
        case ($urandom_range(0, 5))
          0:       d = r;
          1, 2:    d = r >> $urandom_range(0, 31);
          3:       d = ~(r >> $urandom_range(0, 31));
          4:       d = ($urandom_range(0, 1) != 0) ? 32'h0 : 32'hFFFF_FFFF;
          default: d = 32'h1 << $urandom_range(0, 31);
        endcase
        sg       = 1'($urandom_range(0, 1));
        i_valid  = 1'b1;
        i_data   = d;
        i_signed = sg;
        sb.push_back(model(d, sg));
        sent++;
      end else begin
        i_valid = 1'b0;
      end
    end
    i_valid = 1'b0;
    if (got < NW) begin
      tests++; fails++; $display("FAIL rnd_timeout: got %0d results want %0d", got, NW);
    end
    tests++; if (sb.size() != 0) begin fails++; $display("FAIL rnd_leftover: got %0d pending want 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
